uart_tx_fifo: RTL and testbench

Buffered 8N1 UART transmitter. It accepts bytes from any producer in the `mclk` domain, for example the `uart_rx` byte stream or a command/response engine, and queues them in an internal FIFO. It serializes them LSB-first onto the FTDI TX line at the rate set by an external `baud_x1` strobe from `divide_by_n`. It is the buffered transmit counterpart of the existing receiver path: producers can burst bytes faster than the line drains them without losing data.

---
 rtl/uart_tx_fifo.sv | 148 ++++++++++++++
 tb/tb_uart_tx_fifo.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: a small FIFO in front of a baud-strobed
// serializer that sends bytes LSB-first and chains frames without idle gaps.
module uart_tx_fifo #(
  parameter int FIFO_ADDR_W = 4,
  parameter int STOP_BITS   = 1
) (
  input  logic                   mclk,
  input  logic                   reset,
  input  logic                   baud_x1,
  input  logic [7:0]             data,
  input  logic                   data_strobe,
  output logic                   serial,
  output logic                   full,
  output logic [FIFO_ADDR_W:0]   count,
  output logic                   busy,
  output logic                   overflow
);

  localparam int DEPTH = 1 << FIFO_ADDR_W;
  // Count value that means "every slot occupied".
  localparam logic [FIFO_ADDR_W:0] DEPTH_CNT = {1'b1, {FIFO_ADDR_W{1'b0}}};
  // Stop-bit counter value on the last stop bit (counter is one bit wide).
  localparam logic STOP_LAST = (STOP_BITS == 2) ? 1'b1 : 1'b0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    STOP = 2'd2
  } state_t;

  state_t                 state, state_next;
  logic [7:0]             mem [DEPTH];
  logic [FIFO_ADDR_W:0]   wr_ptr, rd_ptr;
  logic [FIFO_ADDR_W:0]   wr_ptr_next, rd_ptr_next, count_next;
  logic [8:0]             shift, shift_next;
  logic [3:0]             bit_cnt, bit_cnt_next;
  logic                   stop_cnt, stop_cnt_next;
  logic                   serial_next;
  logic                   push, pop, not_empty, stop_last;

  // Full is taken from the register, so a write while full is dropped even
  // if the serializer pops on the same cycle.
  assign not_empty   = (count != '0);
  assign push        = data_strobe & ~full;
  assign stop_last   = (stop_cnt == STOP_LAST);
  assign pop         = baud_x1 & not_empty &
                       ((state == IDLE) | ((state == STOP) & stop_last));
  assign wr_ptr_next = wr_ptr + {{FIFO_ADDR_W{1'b0}}, push};
  assign rd_ptr_next = rd_ptr + {{FIFO_ADDR_W{1'b0}}, pop};
  assign count_next  = wr_ptr_next - rd_ptr_next;

  // FIFO storage write port; contents are not reset, only the pointers are.
  always_ff @(posedge mclk) begin
    if (reset && push) begin
      mem[wr_ptr[FIFO_ADDR_W-1:0]] <= data;
    end
  end

  // FIFO pointers and the registered status flags derived from them.
  always_ff @(posedge mclk) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      full     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      wr_ptr   <= wr_ptr_next;
      rd_ptr   <= rd_ptr_next;
      count    <= count_next;
      full     <= (count_next == DEPTH_CNT);
      overflow <= data_strobe & full;
    end
  end

  // Serializer state register together with its datapath and line register.
  always_ff @(posedge mclk) begin
    if (!reset) begin
      state    <= IDLE;
      shift    <= '1;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      serial   <= 1'b1;
      busy     <= 1'b0;
    end else begin
      state    <= state_next;
      shift    <= shift_next;
      bit_cnt  <= bit_cnt_next;
      stop_cnt <= stop_cnt_next;
      serial   <= serial_next;
      busy     <= (state_next != IDLE) | (count_next != '0);
    end
  end

  // Next-state logic; the FSM only moves on baud strobes.
  always_comb begin
    state_next = state;
    if (baud_x1) begin
      case (state)
        IDLE: if (not_empty) state_next = DATA;
        DATA: if (bit_cnt == 4'd8) state_next = STOP;
        STOP: if (stop_last) state_next = not_empty ? DATA : IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Line value and shift/counter updates for the upcoming bit period.
  always_comb begin
    serial_next   = serial;
    shift_next    = shift;
    bit_cnt_next  = bit_cnt;
    stop_cnt_next = stop_cnt;
    if (baud_x1) begin
      case (state)
        IDLE: begin
          serial_next = 1'b1;
        end
        DATA: begin
          // Ones shift in from the top, so the ninth strobe drives the stop level.
          serial_next = shift[0];
          shift_next  = {1'b1, shift[8:1]};
          if (bit_cnt == 4'd8) begin
            stop_cnt_next = 1'b0;
          end else begin
            bit_cnt_next = bit_cnt + 4'd1;
          end
        end
        STOP: begin
          serial_next = 1'b1;
          if (!stop_last) begin
            stop_cnt_next = stop_cnt + 1'b1;
          end
        end
        default: begin
          serial_next = 1'b1;
        end
      endcase
      // Loading the next byte drives its start bit on the same strobe.
      if (pop) begin
        shift_next   = {1'b1, mem[rd_ptr[FIFO_ADDR_W-1:0]]};
        serial_next  = 1'b0;
        bit_cnt_next = 4'd0;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed self-checking bench for uart_tx_fifo: reset state, single and
// chained frames, FIFO fill/overflow, push-while-full, reset mid-frame and
// a two-stop-bit instance running at one bit per clock.
module tb_uart_tx_fifo;

  logic       mclk = 1'b0;
  logic       reset = 1'b0;
  logic       baud_gen = 1'b0;
  logic       baud_man = 1'b0;
  logic       baud_x1;
  logic [7:0] data = 8'h00;
  logic       data_strobe = 1'b0;
  logic       serial, full, busy, overflow;
  logic [4:0] count;

  logic       baud2 = 1'b0;
  logic [7:0] data2 = 8'h00;
  logic       strobe2 = 1'b0;
  logic       serial2, full2, busy2, overflow2;
  logic [4:0] count2;

  int num_checks = 0;
  int num_errors = 0;
  int baud_div = 0;
  logic [7:0] exp_q [$];

  typedef struct {
    logic [7:0] din;
    logic [4:0] exp_count;
    logic       exp_full;
    logic       exp_ovf;
  } vec_t;
  vec_t vecs [17];

  assign baud_x1 = baud_gen | baud_man;

  always #5 mclk = ~mclk;

  uart_tx_fifo #(.FIFO_ADDR_W(4), .STOP_BITS(1)) dut (
    .mclk(mclk), .reset(reset), .baud_x1(baud_x1), .data(data),
    .data_strobe(data_strobe), .serial(serial), .full(full),
    .count(count), .busy(busy), .overflow(overflow)
  );

  uart_tx_fifo #(.FIFO_ADDR_W(4), .STOP_BITS(2)) dut2 (
    .mclk(mclk), .reset(reset), .baud_x1(baud2), .data(data2),
    .data_strobe(strobe2), .serial(serial2), .full(full2),
    .count(count2), .busy(busy2), .overflow(overflow2)
  );

  // Baud strobe generator: one-cycle pulse every baud_div cycles, off when 0.
  initial begin
    int bcnt;
    bcnt = 0;
    forever begin
      @(posedge mclk);
      #1;
      if (baud_div == 0) begin
        baud_gen = 1'b0;
        bcnt = 0;
      end else begin
        baud_gen = (bcnt == 0);
        bcnt = (bcnt + 1 >= baud_div) ? 0 : bcnt + 1;
      end
    end
  end

  task automatic tick();
    @(posedge mclk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    num_checks++;
    if (act !== exp) begin
      num_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic cur_serial(input int which);
    return (which == 2) ? serial2 : serial;
  endfunction

  task automatic write_byte(input logic [7:0] b);
    data = b;
    data_strobe = 1'b1;
    tick();
    data_strobe = 1'b0;
  endtask

  // Wait (bounded) until the chosen line shows a start bit.
  task automatic wait_start(input int which);
    for (int w = 0; w < 3000 && cur_serial(which) !== 1'b0; w++) tick();
    check("start_seen", {31'd0, cur_serial(which)}, 32'd0);
  endtask

  // Starting on the first start-bit sample, check every cycle of the frames
  // in exp_q back to back; each bit must last exactly `period` cycles.
  task automatic check_frames(input int which, input int period, input int stop_bits);
    foreach (exp_q[i]) begin
      logic [10:0] fr;
      fr = {2'b11, exp_q[i], 1'b0};
      for (int j = 0; j < 9 + stop_bits; j++) begin
        for (int p = 0; p < period; p++) begin
          check($sformatf("frame%0d_bit%0d_cyc%0d", i, j, p),
                {31'd0, cur_serial(which)}, {31'd0, fr[j]});
          tick();
        end
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  initial begin
    // Fill/overflow vectors: 16 accepted writes, then one dropped write.
    for (int i = 0; i < 16; i++) begin
      vecs[i].din       = 8'(i);
      vecs[i].exp_count = 5'(i + 1);
      vecs[i].exp_full  = (i == 15);
      vecs[i].exp_ovf   = 1'b0;
    end
    vecs[16].din = 8'h10; vecs[16].exp_count = 5'd16;
    vecs[16].exp_full = 1'b1; vecs[16].exp_ovf = 1'b1;

    // Reset state
    reset = 1'b0;
    tick(); tick(); tick();
    check("rst_serial", {31'd0, serial}, 32'd1);
    check("rst_full", {31'd0, full}, 32'd0);
    check("rst_count", {27'd0, count}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    reset = 1'b1;
    tick();

    // Single byte 0x55, one bit every 16 cycles
    baud_div = 16;
    tick();
    write_byte(8'h55);
    check("single_busy", {31'd0, busy}, 32'd1);
    wait_start(1);
    exp_q = '{8'h55};
    check_frames(1, 16, 1);
    check("single_idle", {31'd0, serial}, 32'd1);
    check("single_busy_end", {31'd0, busy}, 32'd0);
    check("single_count_end", {27'd0, count}, 32'd0);

    // Back-to-back 0xA5, 0x3C with no idle gap
    baud_div = 4;
    tick();
    data = 8'hA5; data_strobe = 1'b1; tick();
    data = 8'h3C; tick();
    data_strobe = 1'b0;
    wait_start(1);
    check("b2b_count", {27'd0, count}, 32'd1);
    exp_q = '{8'hA5, 8'h3C};
    check_frames(1, 4, 1);
    check("b2b_idle", {31'd0, serial}, 32'd1);
    check("b2b_busy_end", {31'd0, busy}, 32'd0);

    // Fill to 16 with no strobes, 17th write overflows
    baud_div = 0;
    tick(); tick();
    for (int i = 0; i < 17; i++) begin
      data = vecs[i].din;
      data_strobe = 1'b1;
      tick();
      check($sformatf("fill%0d_count", i), {27'd0, count}, {27'd0, vecs[i].exp_count});
      check($sformatf("fill%0d_full", i), {31'd0, full}, {31'd0, vecs[i].exp_full});
      check($sformatf("fill%0d_ovf", i), {31'd0, overflow}, {31'd0, vecs[i].exp_ovf});
    end
    data_strobe = 1'b0;
    tick();
    check("fill_ovf_pulse_end", {31'd0, overflow}, 32'd0);
    check("fill_count_hold", {27'd0, count}, 32'd16);
    check("fill_serial_idle", {31'd0, serial}, 32'd1);
    baud_div = 2;
    wait_start(1);
    exp_q.delete();
    for (int i = 0; i < 16; i++) exp_q.push_back(8'(i));
    check_frames(1, 2, 1);
    for (int i = 0; i < 40; i++) begin
      check("drain_idle", {31'd0, serial}, 32'd1);
      tick();
    end
    check("drain_count", {27'd0, count}, 32'd0);
    check("drain_busy", {31'd0, busy}, 32'd0);

    // Push while full with a same-cycle pop
    baud_div = 0;
    tick(); tick();
    do_reset();
    for (int i = 0; i < 16; i++) write_byte(8'(8'h20 + i));
    check("pwf_full_before", {31'd0, full}, 32'd1);
    data = 8'h99; data_strobe = 1'b1; baud_man = 1'b1;
    tick();
    data_strobe = 1'b0; baud_man = 1'b0;
    check("pwf_overflow", {31'd0, overflow}, 32'd1);
    check("pwf_count", {27'd0, count}, 32'd15);
    check("pwf_full_after", {31'd0, full}, 32'd0);
    check("pwf_start_bit", {31'd0, serial}, 32'd0);
    tick();
    check("pwf_overflow_end", {31'd0, overflow}, 32'd0);

    // Reset mid-frame during bit 4 of 0x00, with another byte queued
    do_reset();
    baud_div = 4;
    tick();
    write_byte(8'h00);
    write_byte(8'hFF);
    wait_start(1);
    for (int i = 0; i < 21; i++) tick();
    check("mid_bit4", {31'd0, serial}, 32'd0);
    reset = 1'b0;
    data = 8'h77; data_strobe = 1'b1;
    tick();
    data_strobe = 1'b0;
    check("mid_rst_serial", {31'd0, serial}, 32'd1);
    check("mid_rst_count", {27'd0, count}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    tick();
    reset = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      check("mid_after_idle", {31'd0, serial}, 32'd1);
    end
    check("mid_after_count", {27'd0, count}, 32'd0);
    baud_div = 0;

    // Two stop bits, strobe every cycle, two 0x00 frames
    baud2 = 1'b1;
    data2 = 8'h00; strobe2 = 1'b1;
    tick(); tick();
    strobe2 = 1'b0;
    wait_start(2);
    exp_q = '{8'h00, 8'h00};
    check_frames(2, 1, 2);
    check("stop2_idle", {31'd0, serial2}, 32'd1);
    check("stop2_busy_end", {31'd0, busy2}, 32'd0);
    check("stop2_count_end", {27'd0, count2}, 32'd0);
    check("stop2_full", {31'd0, full2}, 32'd0);
    check("stop2_overflow", {31'd0, overflow2}, 32'd0);
    baud2 = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

endmodule
